// File: rtl/booth_dot_ctrl.sv
// -----------------------------------------------------------------------------
// booth_dot_ctrl
//
// Sequencer and accumulator wrapped around a booth multiplier. Signed operand
// pairs arrive on a valid/ready stream. Each pair goes to the multiplier with
// a one-cycle start pulse. The block waits for the multiplier's completion
// edge and adds the product into a signed accumulator. After N_TERMS products
// it presents the dot product, together with a sticky overflow flag, on a
// valid/ready output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   in_valid_i   operand pair offered
//   in_ready_o   block can accept a pair (IDLE only)
//   in_x_i       signed operand X
//   in_y_i       signed operand Y
//   mul_start_o  one-cycle start pulse to the multiplier
//   mul_x_o      operand X to the multiplier, held until the product is taken
//   mul_y_o      operand Y to the multiplier, held until the product is taken
//   mul_valid_i  multiplier done (pulse or level; only the rising edge counts)
//   mul_z_i      signed product from the multiplier
//   out_valid_o  result available
//   out_ready_i  downstream accepts the result
//   out_acc_o    signed dot-product result (meaningful while out_valid_o=1)
//   out_ovf_o    sticky signed overflow seen while building this result
// -----------------------------------------------------------------------------
module booth_dot_ctrl #(
    parameter int OP_W    = 4,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OP_W-1:0]     in_x_i,
    input  logic [OP_W-1:0]     in_y_i,
    output logic                mul_start_o,
    output logic [OP_W-1:0]     mul_x_o,
    output logic [OP_W-1:0]     mul_y_o,
    input  logic                mul_valid_i,
    input  logic [2*OP_W-1:0]   mul_z_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ACC_W-1:0]    out_acc_o,
    output logic                out_ovf_o
);

    // The counter has room for N_TERMS itself. The increment on the last
    // term therefore never wraps before DONE clears the counter.
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam int EXT_W = ACC_W + 1 - 2 * OP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [OP_W-1:0]    mul_x_q, mul_x_d;
    logic [OP_W-1:0]    mul_y_q, mul_y_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               mul_valid_q;

    logic               mul_done;
    logic               last_term;
    logic [ACC_W:0]     sum_ext;

    // Only a rising edge of mul_valid_i completes a term. A multiplier that
    // holds valid as a level is therefore counted once per product.
    assign mul_done  = mul_valid_i & ~mul_valid_q;
    assign last_term = (count_q == CNT_W'(N_TERMS - 1));

    // The sum uses one guard bit. If the top two bits disagree, the true
    // result does not fit in ACC_W signed bits.
    assign sum_ext = {acc_q[ACC_W-1], acc_q}
                   + {{EXT_W{mul_z_i[2*OP_W-1]}}, mul_z_i};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so that no
        // path through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        in_ready_o  = 1'b0;
        mul_start_o = 1'b0;
        out_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mul_x_d = in_x_i;
                    mul_y_d = in_y_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    count_d = count_q + CNT_W'(1);
                    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                        ovf_d = 1'b1;
                    end
                    state_d = last_term ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the values from before the edge, whatever the statement order.
        if (rst_i) begin
            state_q     <= IDLE;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            mul_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            // The edge detector tracks mul_valid_i in every state. An edge
            // that occurs outside WAIT is therefore absorbed and never counted later.
            mul_valid_q <= mul_valid_i;
        end
    end

    assign mul_x_o   = mul_x_q;
    assign mul_y_o   = mul_y_q;
    assign out_acc_o = acc_q;
    assign out_ovf_o = ovf_q;

endmodule

// File: tb/tb_booth_dot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_dot_ctrl
//
// Scoreboard bench for booth_dot_ctrl. A behavioural multiplier model has a
// programmable latency and can either pulse or hold its valid output. The
// driver pushes each accepted pair into an issue queue. At the end of each
// frame it pushes the expected dot product, computed with plain integer
// arithmetic and explicit wrap, into a result queue. A monitor pops and
// compares these entries whenever the DUT issues a start or presents a result.
// The accumulator is 8 bits wide so that overflow and wrap occur regularly.
// -----------------------------------------------------------------------------
module tb_booth_dot_ctrl;

    localparam int OP_W    = 4;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 8;

    logic                clk_i;
    logic                rst_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [OP_W-1:0]     in_x_i;
    logic [OP_W-1:0]     in_y_i;
    logic                mul_start_o;
    logic [OP_W-1:0]     mul_x_o;
    logic [OP_W-1:0]     mul_y_o;
    logic                mul_valid_i;
    logic [2*OP_W-1:0]   mul_z_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [ACC_W-1:0]    out_acc_o;
    logic                out_ovf_o;

    booth_dot_ctrl #(
        .OP_W    (OP_W),
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .in_y_i      (in_y_i),
        .mul_start_o (mul_start_o),
        .mul_x_o     (mul_x_o),
        .mul_y_o     (mul_y_o),
        .mul_valid_i (mul_valid_i),
        .mul_z_i     (mul_z_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_acc_o   (out_acc_o),
        .out_ovf_o   (out_ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct { int x; int y; } pair_t;
    typedef struct { int acc; int ovf; } res_t;

    pair_t issue_q[$];
    res_t  exp_q[$];

    int checks        = 0;
    int failures      = 0;
    int pairs_sent    = 0;
    int starts_seen   = 0;
    int frames_pushed = 0;
    int results_seen  = 0;

    // Reference model state for the frame being built.
    int m_acc   = 0;
    int m_ovf   = 0;
    int m_terms = 0;

    // Multiplier model and downstream controls.
    int mul_lat  = 3;
    bit mul_hold = 1'b0;
    int bp_len   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two's-complement wrap of an integer into ACC_W signed bits.
    function automatic int wrap_acc(input int s);
        int m;
        int r;
        m = 1 << ACC_W;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_add(input int x, input int y);
        int s;
        res_t r;
        s = m_acc + x * y;
        if (s > (1 << (ACC_W - 1)) - 1 || s < -(1 << (ACC_W - 1))) m_ovf = 1;
        m_acc = wrap_acc(s);
        m_terms++;
        if (m_terms == N_TERMS) begin
            r.acc = m_acc;
            r.ovf = m_ovf;
            exp_q.push_back(r);
            frames_pushed++;
            m_acc   = 0;
            m_ovf   = 0;
            m_terms = 0;
        end
    endtask

    // Entered and left #1 after a rising edge. Holds in_valid_i high until the
    // DUT is ready. The model is updated before the accepting edge, so the
    // monitor never races the driver on the queues.
    task automatic send_pair(input int x, input int y);
        int n;
        pair_t p;
        logic [31:0] xv;
        logic [31:0] yv;
        xv = x;
        yv = y;
        in_x_i     = xv[OP_W-1:0];
        in_y_i     = yv[OP_W-1:0];
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", 0, 1);
            in_valid_i = 1'b0;
            return;
        end
        p.x = x;
        p.y = y;
        issue_q.push_back(p);
        pairs_sent++;
        model_add(x, y);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((results_seen != frames_pushed || !in_ready_o) && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
    endtask

    // Behavioural multiplier. After a start pulse it waits mul_lat cycles and
    // then raises valid with the product. In pulse mode valid drops on the
    // next cycle. In hold mode valid stays high until the next start.
    initial begin
        int mcnt;
        bit mbusy;
        int px;
        int py;
        logic [31:0] prod;
        mcnt        = 0;
        mbusy       = 1'b0;
        px          = 0;
        py          = 0;
        mul_valid_i = 1'b0;
        mul_z_i     = '0;
        forever begin
            @(posedge clk_i); #1;
            if (mul_start_o) begin
                px          = int'($signed(mul_x_o));
                py          = int'($signed(mul_y_o));
                mcnt        = mul_lat;
                mbusy       = 1'b1;
                mul_valid_i = 1'b0;
            end else if (mbusy) begin
                mcnt--;
                if (mcnt == 0) begin
                    prod        = px * py;
                    mul_z_i     = prod[2*OP_W-1:0];
                    mul_valid_i = 1'b1;
                    mbusy       = 1'b0;
                end
            end else if (!mul_hold) begin
                mul_valid_i = 1'b0;
            end
        end
    end

    // Downstream. While out_valid_o is high, out_ready_i is held low for
    // bp_len cycles and then raised.
    initial begin
        int hold;
        hold        = 0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (out_valid_o) begin
                if (hold < bp_len) begin
                    out_ready_i = 1'b0;
                    hold++;
                end else begin
                    out_ready_i = 1'b1;
                end
            end else begin
                hold        = 0;
                out_ready_i = (bp_len == 0);
            end
        end
    end

    // Monitor. Checks start pulses against the issue queue and results
    // against the expected queue. It also checks handshake behaviour around DONE.
    initial begin
        bit   prev_start;
        bit   prev_valid;
        res_t cur;
        pair_t p;
        prev_start = 1'b0;
        prev_valid = 1'b0;
        cur.acc    = 0;
        cur.ovf    = 0;
        forever begin
            @(posedge clk_i); #1;
            if (mul_start_o) begin
                starts_seen++;
                check("start_width", prev_start, 0);
                if (issue_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    p = issue_q.pop_front();
                    check("mul_x", int'($signed(mul_x_o)), p.x);
                    check("mul_y", int'($signed(mul_y_o)), p.y);
                end
            end
            if (out_valid_o) begin
                if (!prev_valid) begin
                    results_seen++;
                    if (exp_q.size() == 0) begin
                        check("result_unexpected", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("out_acc", int'($signed(out_acc_o)), cur.acc);
                        check("out_ovf", out_ovf_o, cur.ovf);
                    end
                end else begin
                    check("out_acc_held", int'($signed(out_acc_o)), cur.acc);
                    check("out_ovf_held", out_ovf_o, cur.ovf);
                end
                check("in_ready_in_done", in_ready_o, 0);
            end else if (prev_valid) begin
                check("in_ready_after_done", in_ready_o, 1);
            end
            prev_start = mul_start_o;
            prev_valid = out_valid_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, results=%0d frames=%0d",
                 results_seen, frames_pushed);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        in_x_i     = '0;
        in_y_i     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_in_ready",  in_ready_o,  1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_mul_start", mul_start_o, 0);
        check("rst_mul_x",     mul_x_o,     0);
        check("rst_mul_y",     mul_y_o,     0);
        check("rst_out_acc",   out_acc_o,   0);
        check("rst_out_ovf",   out_ovf_o,   0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Basic dot product, pulsed completion: 35-24-6+64 = 69.
        mul_lat = 3; mul_hold = 1'b0; bp_len = 0;
        send_pair(5, 7); send_pair(-4, 6); send_pair(3, -2); send_pair(-8, -8);
        drain();

        // Same frame under 5 cycles of backpressure. The overflow frame's first
        // pair is already offered and must wait.
        bp_len = 5;
        send_pair(5, 7); send_pair(-4, 6); send_pair(3, -2); send_pair(-8, -8);
        send_pair(-8, -8);
        bp_len = 0;
        send_pair(-8, -8); send_pair(-8, -8); send_pair(-8, -8);
        send_pair(1, 1); send_pair(1, 1); send_pair(1, 1); send_pair(1, 1);
        drain();

        // Level-held completion must be counted once per product.
        mul_hold = 1'b1;
        mul_lat  = 2;
        send_pair(2, 3); send_pair(1, -1); send_pair(0, 5); send_pair(-3, 0);
        mul_lat  = 1;
        send_pair(7, 7); send_pair(-8, 7); send_pair(2, 2); send_pair(-1, -1);
        drain();
        mul_hold = 1'b0;

        // Reset while WAIT is outstanding. The late product must be ignored.
        mul_lat = 6;
        send_pair(3, 3);
        send_pair(1, 2);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        m_acc   = 0;
        m_ovf   = 0;
        m_terms = 0;
        check("midrst_in_ready",  in_ready_o,  1);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_out_acc",   out_acc_o,   0);
        repeat (10) @(posedge clk_i);
        #1;
        check("late_prod_in_ready",  in_ready_o,  1);
        check("late_prod_out_valid", out_valid_o, 0);
        check("late_prod_out_acc",   out_acc_o,   0);
        mul_lat = 1;
        send_pair(5, 7); send_pair(5, 7); send_pair(5, 7); send_pair(5, 7);
        drain();

        // Randomised back-to-back frames. Latency, completion style and
        // backpressure vary from frame to frame.
        for (int f = 0; f < 24; f++) begin
            mul_lat  = $urandom_range(1, 10);
            mul_hold = 1'($urandom_range(0, 1));
            bp_len   = (f % 4 == 3) ? int'($urandom_range(1, 4)) : 0;
            for (int t = 0; t < N_TERMS; t++) begin
                send_pair(int'($urandom_range(0, 15)) - 8,
                          int'($urandom_range(0, 15)) - 8);
            end
        end
        bp_len = 0;
        drain();

        check("starts_vs_pairs",   starts_seen,   pairs_sent);
        check("results_vs_frames", results_seen,  frames_pushed);
        check("exp_queue_empty",   exp_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
